// File: rtl/vga_pkg.sv
// Shared constants for the bus-mapped VGA display: register map, CTRL bits,
// counter width and default 640x480@60 timing.
package vga_pkg;

   localparam logic [7:0] OFF_X    = 8'd0;
   localparam logic [7:0] OFF_Y    = 8'd1;
   localparam logic [7:0] OFF_PIX  = 8'd2;
   localparam logic [7:0] OFF_PIDX = 8'd3;
   localparam logic [7:0] OFF_PDAT = 8'd4;
   localparam logic [7:0] OFF_CTRL = 8'd5;
   localparam int         N_REGS   = 6;

   localparam int         CTRL_EN   = 0;
   localparam int         CTRL_AUTO = 1;
   localparam int         CTRL_SYNC = 2;
   localparam logic [2:0] CTRL_RST  = 3'b001;

   localparam int CNT_W = 12;

   localparam int DEF_H_VIS  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_VIS  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus horizontal/vertical counters; produces raw
// (unpipelined) sync, visible-area flag and the vblank-start strobe.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int H_VIS   = DEF_H_VIS,
   parameter int H_FP    = DEF_H_FP,
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BP    = DEF_H_BP,
   parameter int V_VIS   = DEF_V_VIS,
   parameter int V_FP    = DEF_V_FP,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BP    = DEF_V_BP
)(
   input  logic             clk,
   input  logic             rst,
   output logic             tick,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             hs_raw,
   output logic             vs_raw,
   output logic             active,
   output logic             vblank_start
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   logic [7:0] div_cnt;
   logic       h_end;
   logic       v_end;

   assign tick  = (div_cnt == 8'(CLK_DIV - 1));
   assign h_end = (h_cnt == CNT_W'(H_TOT - 1));
   assign v_end = (v_cnt == CNT_W'(V_TOT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 8'd1;
         if (tick) begin
            h_cnt <= h_end ? '0 : h_cnt + CNT_W'(1);
            if (h_end)
               v_cnt <= v_end ? '0 : v_cnt + CNT_W'(1);
         end
      end
   end

   assign hs_raw = !((h_cnt >= CNT_W'(H_VIS + H_FP)) && (h_cnt < CNT_W'(H_VIS + H_FP + H_SYNC)));
   assign vs_raw = !((v_cnt >= CNT_W'(V_VIS + V_FP)) && (v_cnt < CNT_W'(V_VIS + V_FP + V_SYNC)));
   assign active = (h_cnt < CNT_W'(H_VIS)) && (v_cnt < CNT_W'(V_VIS));
   // Fires on the tick that moves the counters onto the first front-porch line.
   assign vblank_start = tick && h_end && (v_cnt == CNT_W'(V_VIS - 1));

endmodule

// File: rtl/vga_bus_display.sv
// Bus-mapped VGA display: register window, BPP-deep frame buffer with cursor
// auto-increment, double-buffered palette and a two-tick pixel pipeline.
module vga_bus_display
   import vga_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'hB0,
   parameter int BPP     = 1,
   parameter int FB_W    = 160,
   parameter int FB_H    = 120,
   parameter int SCALE   = 4,
   parameter int CLK_DIV = 4,
   parameter int H_VIS   = DEF_H_VIS,
   parameter int H_FP    = DEF_H_FP,
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BP    = DEF_H_BP,
   parameter int V_VIS   = DEF_V_VIS,
   parameter int V_FP    = DEF_V_FP,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BP    = DEF_V_BP
)(
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] BUS_ADDR,
   input  logic [7:0] BUS_DATA,
   input  logic       BUS_WE,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic [7:0] VGA_COLOUR,
   output logic       FRAME_IRQ
);

   localparam int NPAL = 2 ** BPP;
   localparam int FB_N = FB_W * FB_H;
   localparam int AW   = $clog2(FB_N);

   logic             tick, hs_raw, vs_raw, active, vblank_start;
   logic [CNT_W-1:0] h_cnt, v_cnt;

   logic [7:0]     off;
   logic           wr, pix_ok, fb_we;
   logic [7:0]     x_q, y_q;
   logic [BPP-1:0] pidx_q;
   logic [2:0]     ctrl_q;
   logic [7:0]     shadow_pal [NPAL];
   logic [7:0]     active_pal [NPAL];

   logic [BPP-1:0] fb [FB_N];
   logic [AW-1:0]  rd_addr_p0, wr_addr;
   logic [BPP-1:0] pix_p1;
   logic           vld_p1, hs_p1, vs_p1;

   vga_timing_gen #(
      .CLK_DIV(CLK_DIV),
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk(CLK), .rst(RESET), .tick(tick), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .hs_raw(hs_raw), .vs_raw(vs_raw), .active(active), .vblank_start(vblank_start)
   );

   // Subtraction wraps, so one unsigned compare decodes the window.
   assign off     = BUS_ADDR - BASE_ADDR;
   assign wr      = BUS_WE && (off < 8'(N_REGS));
   assign pix_ok  = (int'(x_q) < FB_W) && (int'(y_q) < FB_H);
   assign fb_we   = wr && (off == OFF_PIX) && pix_ok;
   assign wr_addr = AW'(int'(y_q) * FB_W + int'(x_q));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         x_q    <= '0;
         y_q    <= '0;
         pidx_q <= '0;
         ctrl_q <= CTRL_RST;
         for (int i = 0; i < NPAL; i++)
            shadow_pal[i] <= (i == 0) ? 8'h00 : 8'hFF;
      end else if (wr) begin
         case (off)
            OFF_X:    x_q <= BUS_DATA;
            OFF_Y:    y_q <= BUS_DATA;
            OFF_PIX:
               if (ctrl_q[CTRL_AUTO]) begin
                  if (int'(x_q) == FB_W - 1) begin
                     x_q <= '0;
                     y_q <= (int'(y_q) == FB_H - 1) ? '0 : y_q + 8'd1;
                  end else begin
                     x_q <= x_q + 8'd1;
                  end
               end
            OFF_PIDX: pidx_q <= BUS_DATA[BPP-1:0];
            OFF_PDAT: begin
               shadow_pal[pidx_q] <= BUS_DATA;
               pidx_q             <= pidx_q + BPP'(1);
            end
            OFF_CTRL: ctrl_q <= BUS_DATA[2:0];
            default:  ;
         endcase
      end
   end

   // A PDAT write in the commit cycle reaches shadow only; active takes the old shadow.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NPAL; i++)
            active_pal[i] <= (i == 0) ? 8'h00 : 8'hFF;
      end else if (!ctrl_q[CTRL_SYNC] || FRAME_IRQ) begin
         active_pal <= shadow_pal;
      end
   end

   // p0: frame-buffer address from the current counters
   assign rd_addr_p0 = active ? AW'((int'(v_cnt) / SCALE) * FB_W + int'(h_cnt) / SCALE) : '0;

   // p1: RAM read; same-address write returns old data
   always_ff @(posedge CLK) begin
      if (fb_we)
         fb[wr_addr] <= BUS_DATA[BPP-1:0];
      if (tick)
         pix_p1 <= fb[rd_addr_p0];
   end

   // p2: palette lookup and aligned syncs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         vld_p1     <= 1'b0;
         hs_p1      <= 1'b1;
         vs_p1      <= 1'b1;
         VGA_HS     <= 1'b1;
         VGA_VS     <= 1'b1;
         VGA_COLOUR <= 8'h00;
         FRAME_IRQ  <= 1'b0;
      end else begin
         FRAME_IRQ <= vblank_start;
         if (tick) begin
            vld_p1     <= active;
            hs_p1      <= hs_raw;
            vs_p1      <= vs_raw;
            VGA_HS     <= hs_p1;
            VGA_VS     <= vs_p1;
            VGA_COLOUR <= (vld_p1 && ctrl_q[CTRL_EN]) ? active_pal[pix_p1] : 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_vga_bus_display.sv
// Directed bench for vga_bus_display on a shrunken 16x8-pixel raster so that
// whole frames can be captured and compared against a hand-maintained model.
module tb_vga_bus_display;

   localparam int BPP = 1, FB_W = 8, FB_H = 4, SCALE = 2, CLK_DIV = 2;
   localparam int H_VIS = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_VIS = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
   localparam int H_TOT = 24, V_TOT = 12;
   // Ticks from the FRAME_IRQ edge until pixel (0,0) reaches the outputs.
   localparam int OFS    = 2 + H_TOT * V_TOT - V_VIS * H_TOT;
   localparam int LAST_N = CLK_DIV * (OFS + (V_VIS - 1) * H_TOT + H_VIS - 1);

   localparam logic [7:0] A_X = 8'hB0, A_Y = 8'hB1, A_PIX = 8'hB2;
   localparam logic [7:0] A_PIDX = 8'hB3, A_PDAT = 8'hB4, A_CTRL = 8'hB5;

   logic       CLK, RESET, BUS_WE;
   logic [7:0] BUS_ADDR, BUS_DATA;
   logic       VGA_HS, VGA_VS, FRAME_IRQ;
   logic [7:0] VGA_COLOUR;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [0:0] fb_m   [FB_H][FB_W];
   logic [7:0] act_m  [2];
   logic       en_m;
   logic [7:0] cap    [V_VIS][H_VIS];

   vga_bus_display #(
      .BASE_ADDR(8'hB0), .BPP(BPP), .FB_W(FB_W), .FB_H(FB_H), .SCALE(SCALE),
      .CLK_DIV(CLK_DIV),
      .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
      .BUS_WE(BUS_WE), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_COLOUR(VGA_COLOUR), .FRAME_IRQ(FRAME_IRQ)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
      BUS_ADDR = a;
      BUS_DATA = d;
      BUS_WE   = 1'b1;
      @(negedge CLK);
      BUS_WE   = 1'b0;
   endtask

   task automatic first_hs_low(input string tag);
      int found;
      found = 0;
      for (int k = 1; k <= 200; k++) begin
         @(negedge CLK);
         if (VGA_HS === 1'b0) begin
            found = k;
            break;
         end
      end
      check(tag, 32'(found), 32'(CLK_DIV * (H_VIS + H_FP + 2)));
   endtask

   task automatic do_reset(input string tag);
      RESET = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check({tag, "_hs"},  32'(VGA_HS), 32'd1);
      check({tag, "_vs"},  32'(VGA_VS), 32'd1);
      check({tag, "_col"}, 32'(VGA_COLOUR), 32'd0);
      check({tag, "_irq"}, 32'(FRAME_IRQ), 32'd0);
      RESET = 1'b0;
      first_hs_low({tag, "_first_hs"});
   endtask

   task automatic fall_time(input bit sel_vs, output int t);
      logic prev, cur;
      t    = -100000;
      prev = sel_vs ? VGA_VS : VGA_HS;
      for (int k = 0; k < 2000; k++) begin
         @(negedge CLK);
         cur = sel_vs ? VGA_VS : VGA_HS;
         if (prev && !cur) begin
            t = cyc;
            break;
         end
         prev = cur;
      end
   endtask

   // mode 0: passive; 1: PIDX=1,PDAT=val just after the IRQ cycle; 2: PDAT=val in the IRQ cycle
   task automatic capture_frame(input int mode, input logic [7:0] val);
      bit got_irq;
      int idx;
      got_irq = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge CLK);
         if (FRAME_IRQ === 1'b1) begin
            got_irq = 1'b1;
            break;
         end
      end
      check("irq_seen", 32'(got_irq), 32'd1);
      if (got_irq) begin
         for (int n = 0; n <= LAST_N; n++) begin
            if (n > 0) @(negedge CLK);
            if (n == 1) check("irq_width", 32'(FRAME_IRQ), 32'd0);
            if (mode == 1) begin
               if (n == 1) begin BUS_ADDR = A_PIDX; BUS_DATA = 8'd1; BUS_WE = 1'b1; end
               if (n == 2) begin BUS_ADDR = A_PDAT; BUS_DATA = val; end
               if (n == 3) BUS_WE = 1'b0;
            end else if (mode == 2) begin
               if (n == 0) begin BUS_ADDR = A_PDAT; BUS_DATA = val; BUS_WE = 1'b1; end
               if (n == 1) BUS_WE = 1'b0;
            end
            if ((n % CLK_DIV) == 0 && n / CLK_DIV >= OFS) begin
               idx = n / CLK_DIV - OFS;
               if (idx / H_TOT < V_VIS && idx % H_TOT < H_VIS)
                  cap[idx / H_TOT][idx % H_TOT] = VGA_COLOUR;
            end
         end
      end
   endtask

   task automatic compare_frame(input string name);
      logic [7:0] exp;
      for (int v = 0; v < V_VIS; v++)
         for (int h = 0; h < H_VIS; h++) begin
            exp = en_m ? act_m[fb_m[v / SCALE][h / SCALE]] : 8'h00;
            check($sformatf("%s v%0d h%0d", name, v, h), 32'(cap[v][h]), 32'(exp));
         end
   endtask

   initial begin
      int t1, t2;
      RESET    = 1'b1;
      BUS_WE   = 1'b0;
      BUS_ADDR = 8'h00;
      BUS_DATA = 8'h00;
      en_m     = 1'b1;
      act_m[0] = 8'h00;
      act_m[1] = 8'hFF;
      for (int y = 0; y < FB_H; y++)
         for (int x = 0; x < FB_W; x++)
            fb_m[y][x] = 1'b0;

      do_reset("rst0");

      fall_time(1'b0, t1);
      fall_time(1'b0, t2);
      check("hs_period", 32'(t2 - t1), 32'd48);
      fall_time(1'b1, t1);
      fall_time(1'b1, t2);
      check("vs_period", 32'(t2 - t1), 32'd576);

      // Clear the frame buffer with auto-increment, then a single lit pixel.
      bus_wr(A_CTRL, 8'h03);
      bus_wr(A_X, 8'd0);
      bus_wr(A_Y, 8'd0);
      repeat (FB_W * FB_H) bus_wr(A_PIX, 8'h00);
      bus_wr(A_CTRL, 8'h01);
      bus_wr(A_X, 8'd5);
      bus_wr(A_Y, 8'd2);
      bus_wr(A_PIX, 8'h01);
      fb_m[2][5] = 1'b1;
      capture_frame(0, 8'h00);
      check("t2_lit",  32'(cap[4][10]), 32'hFF);
      check("t2_lit2", 32'(cap[5][11]), 32'hFF);
      check("t2_dark", 32'(cap[4][12]), 32'h00);
      compare_frame("t2");

      // Auto-increment wrap at the last column and row.
      bus_wr(A_CTRL, 8'h03);
      bus_wr(A_X, 8'd7);
      bus_wr(A_Y, 8'd3);
      bus_wr(A_PIX, 8'h01);
      bus_wr(A_PIX, 8'h01);
      bus_wr(A_PIX, 8'h01);
      bus_wr(A_CTRL, 8'h01);
      fb_m[3][7] = 1'b1;
      fb_m[0][0] = 1'b1;
      fb_m[0][1] = 1'b1;
      capture_frame(0, 8'h00);
      check("t3_corner", 32'(cap[7][15]), 32'hFF);
      check("t3_origin", 32'(cap[0][0]), 32'hFF);
      compare_frame("t3");

      // Out-of-window writes ignored; out-of-range cursor drops PIX.
      bus_wr(A_X, 8'd2);
      bus_wr(A_Y, 8'd1);
      bus_wr(8'hAF, 8'h55);
      bus_wr(8'hB6, 8'h55);
      bus_wr(A_PIX, 8'h01);
      fb_m[1][2] = 1'b1;
      bus_wr(A_X, 8'd200);
      bus_wr(A_PIX, 8'h01);
      bus_wr(A_X, 8'd3);
      bus_wr(A_Y, 8'd4);
      bus_wr(A_PIX, 8'h01);
      capture_frame(0, 8'h00);
      check("t5_bg", 32'(cap[0][4]), 32'h00);
      compare_frame("t5");

      // Synchronous palette commit.
      bus_wr(A_CTRL, 8'h05);
      capture_frame(1, 8'hE0);
      check("t4_hold", 32'(cap[4][10]), 32'hFF);
      compare_frame("t4a");
      act_m[1] = 8'hE0;
      capture_frame(0, 8'h00);
      check("t4_new", 32'(cap[4][10]), 32'hE0);
      compare_frame("t4b");

      // PDAT write landing in the commit cycle.
      bus_wr(A_PIDX, 8'd1);
      bus_wr(A_PDAT, 8'h03);
      bus_wr(A_PIDX, 8'd1);
      act_m[1] = 8'h03;
      capture_frame(2, 8'h1C);
      check("t6_old", 32'(cap[4][10]), 32'h03);
      compare_frame("t6a");
      act_m[1] = 8'h1C;
      capture_frame(0, 8'h00);
      check("t6_new", 32'(cap[4][10]), 32'h1C);
      compare_frame("t6b");

      // Display disabled.
      bus_wr(A_CTRL, 8'h00);
      en_m = 1'b0;
      capture_frame(0, 8'h00);
      compare_frame("en0");

      // Mid-frame reset restores palettes and CTRL but keeps frame-buffer contents.
      repeat (150) @(negedge CLK);
      do_reset("rst1");
      en_m     = 1'b1;
      act_m[0] = 8'h00;
      act_m[1] = 8'hFF;
      capture_frame(0, 8'h00);
      check("rst1_keep", 32'(cap[2][4]), 32'hFF);
      compare_frame("rst1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
